// File: rtl/fifo_ram.sv
// Storage array for fifo_ext: synchronous write port, asynchronous read port.
// Held in its own module so the memory mapping (LUT RAM or EBR) can be swapped.
module fifo_ram #(
    parameter int BITWIDTH = 8,
    parameter int BITDEPTH = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [BITDEPTH-1:0] waddr,
    input  logic [BITWIDTH-1:0] wdata,
    input  logic [BITDEPTH-1:0] raddr,
    output logic [BITWIDTH-1:0] rdata
);

    logic [BITWIDTH-1:0] mem [2**BITDEPTH];

    // Write one element per clock; the contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ext.sv
// Single-clock fall-through FIFO with almost-full/almost-empty thresholds, a
// free-slot count, sticky overflow/underflow flags, synchronous flush and a
// high-water-mark tracker. Every status output is registered from next-count.
module fifo_ext #(
    parameter int BITWIDTH     = 8,
    parameter int BITDEPTH     = 4,
    parameter int AFULL_LEVEL  = 2**BITDEPTH - 2,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                clk6x,
    input  logic                resetn,
    input  logic [BITWIDTH-1:0] wport_i,
    input  logic                wenq_i,
    output logic [BITWIDTH-1:0] rport_o,
    input  logic                rdeq_i,
    input  logic                flush_i,
    input  logic                clrerr_i,
    output logic                full_o,
    output logic                empty_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic [BITDEPTH:0]   count_o,
    output logic [BITDEPTH:0]   free_o,
    output logic                overflow_o,
    output logic                underflow_o,
    output logic [BITDEPTH:0]   hwm_o
);

    localparam int DEPTH = 2**BITDEPTH;
    localparam int CW    = BITDEPTH + 1;

    localparam logic [CW-1:0] DEPTH_CW  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CW  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AEMPTY_CW = CW'(AEMPTY_LEVEL);
    localparam logic AFULL_AT_ZERO  = (AFULL_LEVEL <= 0);
    localparam logic AEMPTY_AT_ZERO = (AEMPTY_LEVEL >= 0);

    logic [BITDEPTH-1:0] wptr;
    logic [BITDEPTH-1:0] rptr;
    logic [BITDEPTH-1:0] wptr_next;
    logic [BITDEPTH-1:0] rptr_next;
    logic [CW-1:0]       count_next;
    logic [CW-1:0]       hwm_next;
    logic                acc_w;
    logic                acc_r;
    logic                do_w;
    logic                do_r;
    logic                ovf_set;
    logic                unf_set;

    fifo_ram #(
        .BITWIDTH (BITWIDTH),
        .BITDEPTH (BITDEPTH)
    ) u_ram (
        .clk   (clk6x),
        .we    (do_w),
        .waddr (wptr),
        .wdata (wport_i),
        .raddr (rptr),
        .rdata (rport_o)
    );

    // Decide which operations take effect this edge and derive the next state;
    // a flush discards concurrent requests and suppresses their error events
    always_comb begin
        acc_w      = wenq_i & (~full_o | rdeq_i);
        acc_r      = rdeq_i & ~empty_o;
        do_w       = acc_w & ~flush_i;
        do_r       = acc_r & ~flush_i;
        ovf_set    = ~flush_i & wenq_i & full_o & ~rdeq_i;
        unf_set    = ~flush_i & rdeq_i & empty_o;
        wptr_next  = wptr;
        rptr_next  = rptr;
        count_next = count_o;
        if (flush_i) begin
            wptr_next  = '0;
            rptr_next  = '0;
            count_next = '0;
        end else begin
            if (do_w) begin
                wptr_next = wptr + 1'b1;
            end
            if (do_r) begin
                rptr_next = rptr + 1'b1;
            end
            if (do_w && !do_r) begin
                count_next = count_o + CW'(1);
            end else if (do_r && !do_w) begin
                count_next = count_o - CW'(1);
            end
        end
        if (clrerr_i) begin
            hwm_next = count_next;
        end else if (count_next > hwm_o) begin
            hwm_next = count_next;
        end else begin
            hwm_next = hwm_o;
        end
    end

    // Register pointers, count and all status flags from next-count
    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            wptr           <= '0;
            rptr           <= '0;
            count_o        <= '0;
            free_o         <= DEPTH_CW;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= AFULL_AT_ZERO;
            almost_empty_o <= AEMPTY_AT_ZERO;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
            hwm_o          <= '0;
        end else begin
            wptr           <= wptr_next;
            rptr           <= rptr_next;
            count_o        <= count_next;
            free_o         <= DEPTH_CW - count_next;
            full_o         <= (count_next == DEPTH_CW);
            empty_o        <= (count_next == '0);
            almost_full_o  <= (count_next >= AFULL_CW);
            almost_empty_o <= (count_next <= AEMPTY_CW);
            overflow_o     <= (overflow_o & ~clrerr_i) | ovf_set;
            underflow_o    <= (underflow_o & ~clrerr_i) | unf_set;
            hwm_o          <= hwm_next;
        end
    end

endmodule

// File: tb/tb_fifo_ext.sv
// Directed testbench for fifo_ext with a queue-based scoreboard.
module tb_fifo_ext;

    localparam int BW    = 8;
    localparam int BD    = 4;
    localparam int DEPTH = 16;
    localparam int AFULL = 14;
    localparam int AEMPT = 1;

    logic          clk6x = 1'b0;
    logic          resetn;
    logic [BW-1:0] wport_i;
    logic          wenq_i;
    logic [BW-1:0] rport_o;
    logic          rdeq_i;
    logic          flush_i;
    logic          clrerr_i;
    logic          full_o;
    logic          empty_o;
    logic          almost_full_o;
    logic          almost_empty_o;
    logic [BD:0]   count_o;
    logic [BD:0]   free_o;
    logic          overflow_o;
    logic          underflow_o;
    logic [BD:0]   hwm_o;

    logic [BW-1:0] sb[$];
    logic          m_ovf;
    logic          m_unf;
    int            m_hwm;
    int            total = 0;
    int            bad   = 0;

    fifo_ext #(
        .BITWIDTH     (BW),
        .BITDEPTH     (BD),
        .AFULL_LEVEL  (AFULL),
        .AEMPTY_LEVEL (AEMPT)
    ) dut (
        .clk6x          (clk6x),
        .resetn         (resetn),
        .wport_i        (wport_i),
        .wenq_i         (wenq_i),
        .rport_o        (rport_o),
        .rdeq_i         (rdeq_i),
        .flush_i        (flush_i),
        .clrerr_i       (clrerr_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .free_o         (free_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
        .hwm_o          (hwm_o)
    );

    always #5 clk6x = ~clk6x;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = sb.size();
        check_output({tag, " count"},  32'(count_o),        32'(n));
        check_output({tag, " free"},   32'(free_o),         32'(DEPTH - n));
        check_output({tag, " empty"},  32'(empty_o),        32'(n == 0));
        check_output({tag, " full"},   32'(full_o),         32'(n == DEPTH));
        check_output({tag, " afull"},  32'(almost_full_o),  32'(n >= AFULL));
        check_output({tag, " aempty"}, 32'(almost_empty_o), 32'(n <= AEMPT));
        check_output({tag, " ovf"},    32'(overflow_o),     32'(m_ovf));
        check_output({tag, " unf"},    32'(underflow_o),    32'(m_unf));
        check_output({tag, " hwm"},    32'(hwm_o),          32'(m_hwm));
    endtask

    task automatic model_reset();
        sb.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_hwm = 0;
    endtask

    task automatic apply_stimulus(input string tag, input logic we, input logic [BW-1:0] wd,
                                  input logic re, input logic fl, input logic ce);
        int   n;
        logic acc_w;
        logic acc_r;
        @(negedge clk6x);
        wenq_i   = we;
        wport_i  = wd;
        rdeq_i   = re;
        flush_i  = fl;
        clrerr_i = ce;
        n     = sb.size();
        acc_w = we && (n < DEPTH || re);
        acc_r = re && (n > 0);
        if (acc_r && !fl) begin
            check_output({tag, " rport"}, 32'(rport_o), 32'(sb[0]));
        end
        @(posedge clk6x);
        if (ce) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (we && n == DEPTH && !re) m_ovf = 1'b1;
            if (re && n == 0) m_unf = 1'b1;
            if (acc_r) void'(sb.pop_front());
            if (acc_w) sb.push_back(wd);
        end
        if (ce) m_hwm = sb.size();
        else if (sb.size() > m_hwm) m_hwm = sb.size();
        #1;
        check_all(tag);
    endtask

    initial begin
        resetn   = 1'b0;
        wport_i  = '0;
        wenq_i   = 1'b0;
        rdeq_i   = 1'b0;
        flush_i  = 1'b0;
        clrerr_i = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk6x);
        resetn = 1'b1;

        $display("[TB] basic enqueue/dequeue");
        apply_stimulus("t1_w", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        apply_stimulus("t1_w", 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        apply_stimulus("t1_w", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        check_output("t1 count3", 32'(count_o), 32'd3);
        check_output("t1 free13", 32'(free_o), 32'd13);
        check_output("t1 aempty0", 32'(almost_empty_o), 32'd0);
        check_output("t1 head", 32'(rport_o), 32'h11);
        for (int i = 0; i < 3; i++) apply_stimulus("t1_r", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_output("t1 empty", 32'(empty_o), 32'd1);

        $display("[TB] fill, overflow, drain");
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus("t2_w", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 12) check_output("t2 afull at13", 32'(almost_full_o), 32'd0);
            if (i == 13) check_output("t2 afull at14", 32'(almost_full_o), 32'd1);
        end
        check_output("t2 full", 32'(full_o), 32'd1);
        apply_stimulus("t2_ovf", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        check_output("t2 ovf set", 32'(overflow_o), 32'd1);
        check_output("t2 count16", 32'(count_o), 32'd16);
        for (int i = 0; i < DEPTH; i++) apply_stimulus("t2_r", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        apply_stimulus("t2_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("[TB] full with concurrent enqueue/dequeue");
        for (int i = 0; i < DEPTH; i++) apply_stimulus("t3_w", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) apply_stimulus("t3_wr", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        check_output("t3 full", 32'(full_o), 32'd1);
        check_output("t3 ovf", 32'(overflow_o), 32'd0);
        for (int i = 0; i < DEPTH; i++) apply_stimulus("t3_r", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("[TB] empty with concurrent enqueue/dequeue");
        apply_stimulus("t4_wr", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check_output("t4 unf", 32'(underflow_o), 32'd1);
        check_output("t4 count1", 32'(count_o), 32'd1);
        check_output("t4 head", 32'(rport_o), 32'h77);
        apply_stimulus("t4_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_output("t4 unf clr", 32'(underflow_o), 32'd0);
        check_output("t4 hwm1", 32'(hwm_o), 32'd1);
        apply_stimulus("t4_r", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("[TB] flush");
        for (int i = 0; i < 9; i++) apply_stimulus("t5_w", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        apply_stimulus("t5_fl", 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        check_output("t5 count0", 32'(count_o), 32'd0);
        check_output("t5 free16", 32'(free_o), 32'd16);
        check_output("t5 hwm9", 32'(hwm_o), 32'd9);
        check_output("t5 ovf", 32'(overflow_o), 32'd0);
        apply_stimulus("t5_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("[TB] asynchronous reset mid-burst");
        apply_stimulus("t6_w", 1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        apply_stimulus("t6_w", 1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
        @(negedge clk6x);
        wenq_i  = 1'b1;
        wport_i = 8'hC3;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        @(negedge clk6x);
        wenq_i = 1'b0;
        resetn = 1'b1;
        check_all("t6_held");
        apply_stimulus("t6_resume", 1'b1, 8'hD4, 1'b0, 1'b0, 1'b0);
        apply_stimulus("t6_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
